// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for uart_tx_framer.
// With UART_TX_PARITY_INJECT_EN defined, it also carries inject_perr.
interface uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        parity_type;
  logic              tx_valid;
  logic              tx_ready;
`ifdef UART_TX_PARITY_INJECT_EN
  logic              inject_perr;
`endif

  modport master (
`ifdef UART_TX_PARITY_INJECT_EN
    output inject_perr,
`endif
    output tx_data, parity_type, tx_valid,
    input  tx_ready
  );

  modport slave (
`ifdef UART_TX_PARITY_INJECT_EN
    input  inject_perr,
`endif
    input  tx_data, parity_type, tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, DATA_W data bits LSB first, optional parity, and STOP_BITS stop bits.
// Define UART_TX_PARITY_INJECT_EN to add inject_perr, which inverts the transmitted parity bit.
module uart_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       parity_out
);
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = $clog2(DATA_W);
  localparam int SLEN = STOP_BITS * CLKS_PER_BIT;
  localparam int SW   = (SLEN > 1) ? $clog2(SLEN) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_idx;
  logic [SW-1:0]     stop_cnt;
  logic [DATA_W-1:0] shreg;
  logic              has_par;
  logic              ready_q;
  logic              inj_q;
  logic              bit_end;
  logic              accept;

  assign bus.tx_ready = ready_q;
  assign bit_end      = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign accept       = (state == IDLE) && ready_q && bus.tx_valid;

  // Odd parity is also what mode 11 reports, even though it is not framed.
  function automatic logic calc_par(input logic [DATA_W-1:0] d, input logic [1:0] m);
    case (m)
      2'b00:   return 1'b0;
      2'b10:   return ^d;
      default: return ~^d;
    endcase
  endfunction

`ifdef UART_TX_PARITY_INJECT_EN
  always_ff @(posedge clk) begin
    if (rst)         inj_q <= 1'b0;
    else if (accept) inj_q <= bus.inject_perr;
  end
`else
  assign inj_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      stop_cnt   <= '0;
      shreg      <= '0;
      has_par    <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      ready_q    <= 1'b1;
      parity_out <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            shreg      <= bus.tx_data;
            has_par    <= (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
            parity_out <= calc_par(bus.tx_data, bus.parity_type);
            clk_cnt    <= '0;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            ready_q    <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == BW'(DATA_W - 1)) begin
              if (has_par) begin
                tx    <= parity_out ^ inj_q;
                state <= PARITY;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= SW'(SLEN - 1);
                tx_done  <= (SLEN == 1);
                state    <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            clk_cnt  <= '0;
            tx       <= 1'b1;
            stop_cnt <= SW'(SLEN - 1);
            tx_done  <= (SLEN == 1);
            state    <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // stop_cnt counts down the whole stop period so tx_done lands on its last cycle.
          if (stop_cnt == '0) begin
            tx_busy <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            stop_cnt <= stop_cnt - 1'b1;
            tx_done  <= (stop_cnt == SW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench: two framers (1 and 2 stop bits) compared against a frame-level model.
module tb_uart_tx_framer;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_W(DW)) b0 ();
  uart_tx_if #(.DATA_W(DW)) b1 ();
  logic tx0, busy0, done0, par0;
  logic tx1, busy1, done1, par1;

  uart_tx_framer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .tx(tx0), .tx_busy(busy0), .tx_done(done0), .parity_out(par0));
  uart_tx_framer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .tx(tx1), .tx_busy(busy1), .tx_done(done1), .parity_out(par1));

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int sel    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s (dut%0d t=%0t): observed %0h expected %0h", tag, sel, $time, obs, exp);
    end
  endtask

  function automatic logic o_tx();    return sel ? tx1   : tx0;   endfunction
  function automatic logic o_busy();  return sel ? busy1 : busy0; endfunction
  function automatic logic o_done();  return sel ? done1 : done0; endfunction
  function automatic logic o_par();   return sel ? par1  : par0;  endfunction
  function automatic logic o_ready(); return sel ? b1.tx_ready : b0.tx_ready; endfunction

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [1:0] m, input bit inj);
    if (sel == 0) begin
      b0.tx_valid = v; b0.tx_data = d; b0.parity_type = m; b1.tx_valid = 1'b0;
`ifdef UART_TX_PARITY_INJECT_EN
      b0.inject_perr = inj;
`endif
    end else begin
      b1.tx_valid = v; b1.tx_data = d; b1.parity_type = m; b0.tx_valid = 1'b0;
`ifdef UART_TX_PARITY_INJECT_EN
      b1.inject_perr = inj;
`endif
    end
  endtask

  // Entered at a negedge; returns at the negedge of the idle cycle that follows tx_done.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input bit inj,
                      input bit hold, input logic [DW-1:0] nxt);
    bit q[$];
    int ones, n, len;
    bit pexp, inj_eff;
    n = 0;
    while (o_ready() !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("ready_before_accept", o_ready(), 1);
    drive(1'b1, d, m, inj);
    @(posedge clk);
    #1;
    if (hold) drive(1'b1, nxt, m, 1'b0);
    else      drive(1'b0, DW'($urandom), 2'($urandom), 1'b0);

    ones = 0;
    for (int i = 0; i < DW; i++) ones += d[i];
    pexp = (m == 2'b00) ? 1'b0 : (m == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0);
`ifdef UART_TX_PARITY_INJECT_EN
    inj_eff = inj;
`else
    inj_eff = 1'b0;
`endif
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (m == 2'b01 || m == 2'b10) q.push_back(pexp ^ inj_eff);
    for (int i = 0; i < (sel ? 2 : 1); i++) q.push_back(1'b1);
    len = CPB * q.size();

    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      chk("tx_bit", o_tx(), q[(k - 1) / CPB]);
      chk("tx_done", o_done(), (k == len));
      chk("tx_busy", o_busy(), 1);
      chk("tx_ready_busy", o_ready(), 0);
      if (k == 1) chk("parity_out", o_par(), pexp);
    end
    @(negedge clk);
    chk("idle_ready", o_ready(), 1);
    chk("idle_tx", o_tx(), 1);
    chk("idle_busy", o_busy(), 0);
    chk("idle_done", o_done(), 0);
    chk("parity_hold", o_par(), pexp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.tx_valid = 0; b0.tx_data = '0; b0.parity_type = '0;
    b1.tx_valid = 0; b1.tx_data = '0; b1.parity_type = '0;
`ifdef UART_TX_PARITY_INJECT_EN
    b0.inject_perr = 0; b1.inject_perr = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      chk("rst_tx", o_tx(), 1);
      chk("rst_ready", o_ready(), 1);
      chk("rst_busy", o_busy(), 0);
      chk("rst_done", o_done(), 0);
      chk("rst_par", o_par(), 0);
    end
    rst = 1'b0;

    sel = 0;
    send(8'h55, 2'b01, 1'b0, 1'b0, 8'h00);
    sel = 1;
    send(8'h07, 2'b10, 1'b0, 1'b0, 8'h00);
    sel = 0;
    send(8'hFF, 2'b00, 1'b0, 1'b0, 8'h00);
    send(8'h00, 2'b11, 1'b0, 1'b0, 8'h00);
    // 0xA3 is presented throughout the first frame and must go out next, back-to-back.
    send(8'h3C, 2'b01, 1'b0, 1'b1, 8'hA3);
    send(8'hA3, 2'b01, 1'b0, 1'b0, 8'h00);

    drive(1'b1, 8'h5A, 2'b01, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 8'h00, 2'b00, 1'b0);
    repeat (18) @(negedge clk);
    chk("mid_bit3", o_tx(), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", o_tx(), 1);
    chk("abort_busy", o_busy(), 0);
    chk("abort_ready", o_ready(), 1);
    chk("abort_par", o_par(), 0);
    chk("abort_done", o_done(), 0);
    rst = 1'b0;
    send(8'hC9, 2'b10, 1'b0, 1'b0, 8'h00);

`ifdef UART_TX_PARITY_INJECT_EN
    send(8'h55, 2'b01, 1'b1, 1'b0, 8'h00);
`endif

    for (int r = 0; r < 8; r++) begin
      sel = int'($urandom_range(0, 1));
      send(DW'($urandom), 2'($urandom), 1'($urandom), 1'b0, 8'h00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Parametrised UART transmit framer; successor to the combinational parity generator.
- Accepts a data word over a valid/ready handshake and computes parity per the existing 2-bit parity_type encoding.
- Serialises start, data (LSB first), optional parity and stop bits onto tx at a fixed clocks-per-bit rate.
- Sits between the UART host-side register/FIFO and the pad.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 1.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- tx_data  input  DATA_W  word to transmit
- parity_type  input  2  00 none; 01 odd; 10 even; 11 odd computed on parity_out only, no parity bit in the frame
- tx_valid  input  1  tx_data/parity_type valid
- tx_ready  output  1  framer can accept a word
- tx  output  1  serial line, idle high
- tx_busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse at the end of a frame
- parity_out  output  1  parity of the last accepted word

Behaviour:
- Reset, while rst=1 at a clk edge:
  - FSM goes to IDLE.
  - tx=1, tx_ready=1 after reset, tx_busy=0, tx_done=0, parity_out=0.
  - Bit counter and clock counter cleared.
  - Reset mid-frame aborts the frame; tx=1 from the next cycle; the word is discarded.
- Handshake:
  - Accept occurs at a clk edge with tx_valid=1 and tx_ready=1.
  - tx_ready=1 only in IDLE.
  - tx_valid while busy is ignored, with no queuing.
  - tx_data and parity_type are latched at accept; later changes have no effect on the frame.
- Parity, computed from the latched word at accept and registered into parity_out in the same edge:
  - ones = popcount(tx_data[DATA_W-1:0]).
  - Odd (01, 11): bit = 1 if ones is even, else 0.
  - Even (10): bit = 1 if ones is odd, else 0.
  - None (00): parity_out = 0.
  - parity_out holds until the next accept or reset.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept; tx_busy=1 from the cycle after accept.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx=word[i], i=0..DATA_W-1, each for CLKS_PER_BIT cycles. After the last bit -> PARITY if parity_type is 01 or 10, else -> STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 in the final cycle of STOP; then -> IDLE.
- Latency:
  - tx drops to 0 in the cycle after the accept edge.
  - Frame length = CLKS_PER_BIT*(1+DATA_W+P+STOP_BITS) cycles, where P=1 for modes 01/10 and 0 otherwise.
  - tx_ready returns to 1 the cycle after tx_done.
- Back-to-back: a word may be accepted in the first IDLE cycle, giving one idle-high clk between frames.
- Counters:
  - Clock counter width = clog2(CLKS_PER_BIT), min 1; wraps to 0 at CLKS_PER_BIT-1.
  - Bit index width = clog2(DATA_W).
  - CLKS_PER_BIT=1 is legal: one cycle per bit.
- tx is registered; it never glitches and never takes X after reset.

Optional Feature:
- Macro UART_TX_PARITY_INJECT_EN.
- Defined:
  - Adds input port inject_perr (1 bit), latched at accept.
  - When the latched value is 1 and the frame carries a parity bit, the transmitted parity bit is inverted.
  - parity_out still reports the correct, uninverted parity.
  - Ignored for modes 00/11.
- Undefined: the port does not exist and parity is never inverted.

Test Plan:
- Odd parity, data 0x55: DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, mode 01, accept. Required:
  - parity_out=1.
  - tx sequence 0,1,0,1,0,1,0,1,0,1,1, each bit 4 cycles.
  - tx_done at cycle 44 after the accept edge.
  - tx_ready=1 at cycle 45.
- Even parity and two stop bits: mode 10, data 0x07, STOP_BITS=2. Required: parity bit=1, parity_out=1, stop high for 8 cycles, frame 48 cycles.
- Modes without a parity bit:
  - Mode 00, data 0xFF: no parity bit, parity_out=0, frame 40 cycles.
  - Mode 11, data 0x00: parity_out=1, no parity bit in frame, frame 40 cycles.
- Busy handling and back-to-back:
  - Hold tx_valid=1 with a new word 0xA3 during the frame: ignored until IDLE.
  - Accepted at the first IDLE cycle; exactly one idle-high cycle between frames.
  - Second frame carries 0xA3.
- Reset mid-frame: assert rst during DATA bit 3. Required:
  - tx=1, tx_busy=0, tx_ready=1, parity_out=0 next cycle.
  - A new accept after release sends a full, correct frame.
- With UART_TX_PARITY_INJECT_EN: mode 01, 0x55, inject_perr=1. Required: transmitted parity bit=0, parity_out=1.
